// File: rtl/line_window_3x3_if.sv
// Stream bundle for the 3x3 window stage: the pixel input stream and the window output stream.
// The slave modport is the window stage itself; the master modport is whoever feeds and drains it.
interface line_window_3x3_if #(
  parameter int unsigned PW = 24
) ();

  logic [PW-1:0]   s_axis_tdata;
  logic            s_axis_tvalid;
  logic            s_axis_tready;

  logic [9*PW-1:0] m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tuser;
  logic            m_axis_tlast;

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    output s_axis_tready,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tuser,
    output m_axis_tlast
  );

  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    input  s_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tuser,
    input  m_axis_tlast
  );

endinterface

// File: rtl/line_window_3x3.sv
// 3x3 sliding-window generator over an {R,G,B} raster with two on-chip line buffers.
// Valid padding only: a window is emitted for every accepted pixel at row>=2, col>=2.
module line_window_3x3 #(
  parameter int unsigned WIDTH      = 640,
  parameter int unsigned HEIGHT     = 480,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   frame_start,
  line_window_3x3_if.slave       axis,
  output logic                   frame_done
);

  localparam int unsigned PW = 3 * DATA_WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned RW = $clog2(HEIGHT);

  localparam logic [CW-1:0] ColLast = CW'(WIDTH - 1);
  localparam logic [RW-1:0] RowLast = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] ColTwo  = CW'(2);
  localparam logic [RW-1:0] RowTwo  = RW'(2);

  logic [CW-1:0]   col_q, col_d, col_cur;
  logic [RW-1:0]   row_q, row_d, row_cur;

  logic [PW-1:0]   lb0_q [WIDTH];
  logic [PW-1:0]   lb1_q [WIDTH];

  logic [PW-1:0]   win_q [9];
  logic [PW-1:0]   win_d [9];
  logic [9*PW-1:0] win_flat;

  logic [9*PW-1:0] tdata_q, tdata_d;
  logic            tvalid_q, tvalid_d;
  logic            tuser_q, tuser_d;
  logic            tlast_q, tlast_d;
  logic            frame_done_q, frame_done_d;

  logic            s_ready, in_fire, out_fire, qualify;
  logic            col_end, row_end;
  logic [PW-1:0]   tap_top, tap_mid;

  assign s_ready  = enable && (!tvalid_q || axis.m_axis_tready);
  assign in_fire  = axis.s_axis_tvalid && s_ready;
  assign out_fire = tvalid_q && axis.m_axis_tready;

  // frame_start overrides the stored position in the same cycle it arrives
  assign col_cur = frame_start ? '0 : col_q;
  assign row_cur = frame_start ? '0 : row_q;
  assign col_end = (col_cur == ColLast);
  assign row_end = (row_cur == RowLast);
  assign qualify = in_fire && (row_cur >= RowTwo) && (col_cur >= ColTwo);

  assign tap_mid = lb0_q[col_cur];
  assign tap_top = lb1_q[col_cur];

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = 1'b0;
    if (in_fire) begin
      if (col_end) begin
        col_d        = '0;
        row_d        = row_end ? '0 : row_cur + RW'(1);
        frame_done_d = row_end;
      end else begin
        col_d = col_cur + CW'(1);
        row_d = row_cur;
      end
    end else if (frame_start) begin
      col_d = '0;
      row_d = '0;
    end
  end

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      win_d[k] = win_q[k];
    end
    if (in_fire) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r*3]     = win_q[r*3+1];
        win_d[r*3 + 1] = win_q[r*3+2];
      end
      win_d[2] = tap_top;
      win_d[5] = tap_mid;
      win_d[8] = axis.s_axis_tdata;
    end
  end

  always_comb begin
    win_flat = '0;
    for (int k = 0; k < 9; k++) begin
      win_flat[k*PW +: PW] = win_d[k];
    end
  end

  // A qualifying accept can only happen when the output slot is free or draining
  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    if (qualify) begin
      tdata_d  = win_flat;
      tvalid_d = 1'b1;
      tuser_d  = (row_cur == RowTwo) && (col_cur == ColTwo);
      tlast_d  = col_end;
    end else if (out_fire) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tuser_q      <= 1'b0;
      tlast_q      <= 1'b0;
      frame_done_q <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tuser_q      <= tuser_d;
      tlast_q      <= tlast_d;
      frame_done_q <= frame_done_d;
      for (int k = 0; k < 9; k++) begin
        win_q[k] <= win_d[k];
      end
    end
  end

  // Line buffer contents need no reset: rows 0 and 1 of every frame overwrite them first
  always_ff @(posedge clk) begin
    if (in_fire) begin
      lb1_q[col_cur] <= lb0_q[col_cur];
      lb0_q[col_cur] <= axis.s_axis_tdata;
    end
  end

  assign axis.s_axis_tready = s_ready;
  assign axis.m_axis_tdata  = tdata_q;
  assign axis.m_axis_tvalid = tvalid_q;
  assign axis.m_axis_tuser  = tuser_q;
  assign axis.m_axis_tlast  = tlast_q;
  assign frame_done         = frame_done_q;

endmodule

// File: tb/tb_line_window_3x3.sv
// Scoreboard bench for line_window_3x3 on a 4x4 raster: a frame-image model predicts each
// window when a pixel is accepted; windows are popped and compared as the DUT emits them.
module tb_line_window_3x3;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned PW = 3 * DW;

  typedef struct packed {
    logic [9*PW-1:0] data;
    logic            user;
    logic            last;
  } win_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic frame_start = 1'b0;
  logic frame_done;

  line_window_3x3_if #(.PW(PW)) axis ();

  line_window_3x3 #(
    .WIDTH(W),
    .HEIGHT(H),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .frame_start(frame_start),
    .axis(axis),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int n_win = 0;
  int fd_seen = 0;
  win_t exp_q[$];
  win_t got_log[$];
  logic [PW-1:0] img [H][W];
  int m_row = 0;
  int m_col = 0;
  bit exp_fd = 1'b0;
  bit rdy_toggle = 1'b0;
  bit prev_stall = 1'b0;
  logic [9*PW-1:0] prev_data = '0;

  function automatic logic [PW-1:0] pix(input int v);
    logic [7:0] b;
    b = 8'(v);
    return {b, b, b};
  endfunction

  function automatic logic [7:0] tap(input logic [9*PW-1:0] d, input int k);
    return d[k*PW +: 8];
  endfunction

  // One clock: called just after a negedge with inputs already driven.
  task automatic cycle(output bit acc);
    bit in_f, out_f, fs, rs;
    logic [PW-1:0] p;
    win_t got, e;
    #1;
    n_checks++;
    if (axis.m_axis_tvalid !== (exp_q.size() != 0)) begin
      n_fail++;
      $display("FAIL tvalid: got %b expected %b", axis.m_axis_tvalid, exp_q.size() != 0);
    end
    n_checks++;
    if (axis.s_axis_tready !== (enable && (exp_q.size() == 0 || axis.m_axis_tready))) begin
      n_fail++;
      $display("FAIL s_tready: got %b expected %b", axis.s_axis_tready,
               enable && (exp_q.size() == 0 || axis.m_axis_tready));
    end
    n_checks++;
    if (frame_done !== exp_fd) begin
      n_fail++;
      $display("FAIL frame_done: got %b expected %b", frame_done, exp_fd);
    end
    if (frame_done === 1'b1) fd_seen++;
    if (prev_stall) begin
      n_checks++;
      if (axis.m_axis_tdata !== prev_data) begin
        n_fail++;
        $display("FAIL stall_hold: got %h expected %h", axis.m_axis_tdata, prev_data);
      end
    end
    out_f = axis.m_axis_tvalid && axis.m_axis_tready;
    if (out_f) begin
      n_win++;
      got = '{data: axis.m_axis_tdata, user: axis.m_axis_tuser, last: axis.m_axis_tlast};
      got_log.push_back(got);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL window_extra: got %h expected none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL window: got %h expected %h", got, e);
        end
      end
    end
    prev_stall = axis.m_axis_tvalid && !axis.m_axis_tready && rst_n;
    prev_data  = axis.m_axis_tdata;
    in_f = axis.s_axis_tvalid && axis.s_axis_tready;
    fs   = frame_start;
    rs   = rst_n;
    p    = axis.s_axis_tdata;
    @(posedge clk);
    exp_fd = 1'b0;
    if (!rs) begin
      m_row = 0;
      m_col = 0;
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (fs) begin
        m_row = 0;
        m_col = 0;
      end
      if (in_f) begin
        img[m_row][m_col] = p;
        if (m_row >= 2 && m_col >= 2) begin
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              e.data[(r*3+c)*PW +: PW] = img[m_row-2+r][m_col-2+c];
          e.user = (m_row == 2 && m_col == 2);
          e.last = (m_col == W - 1);
          exp_q.push_back(e);
        end
        exp_fd = (m_row == H - 1 && m_col == W - 1);
        if (m_col == W - 1) begin
          m_col = 0;
          m_row = (m_row == H - 1) ? 0 : m_row + 1;
        end else begin
          m_col++;
        end
      end
    end
    acc = in_f && rs;
    @(negedge clk);
    if (rdy_toggle) axis.m_axis_tready = ~axis.m_axis_tready;
  endtask

  task automatic send_pixel(input int v);
    bit acc;
    acc = 1'b0;
    axis.s_axis_tdata  = pix(v);
    axis.s_axis_tvalid = 1'b1;
    for (int i = 0; i < 40 && !acc; i++) cycle(acc);
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: pixel %0d got not-accepted expected accepted", v);
    end
  endtask

  task automatic send_frame(input int base);
    for (int v = 0; v < 16; v++) send_pixel(base + v);
  endtask

  task automatic drain();
    bit acc;
    int i;
    axis.s_axis_tvalid = 1'b0;
    i = 0;
    while (i < 30 && (exp_q.size() != 0 || i < 4)) begin
      cycle(acc);
      i++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic start_scenario();
    n_win   = 0;
    fd_seen = 0;
    got_log.delete();
  endtask

  task automatic test_reset();
    bit acc;
    rst_n = 1'b0;
    cycle(acc);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({axis.m_axis_tvalid, axis.m_axis_tuser, axis.m_axis_tlast, frame_done} !== 4'b0 ||
        axis.m_axis_tdata !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v%b u%b l%b fd%b d%h expected all zero",
               axis.m_axis_tvalid, axis.m_axis_tuser, axis.m_axis_tlast, frame_done,
               axis.m_axis_tdata);
    end
    @(negedge clk);
  endtask

  task automatic test_stream();
    start_scenario();
    axis.m_axis_tready = 1'b1;
    send_frame(0);
    drain();
    n_checks++;
    if (n_win != 4) begin
      n_fail++;
      $display("FAIL stream_count: got %0d expected 4", n_win);
    end
    n_checks++;
    if (fd_seen != 1) begin
      n_fail++;
      $display("FAIL stream_frame_done: got %0d pulses expected 1", fd_seen);
    end
    if (got_log.size() == 4) begin
      n_checks++;
      if (tap(got_log[0].data, 0) !== 8'd0 || tap(got_log[0].data, 4) !== 8'd5 ||
          tap(got_log[0].data, 8) !== 8'd10 || got_log[0].user !== 1'b1 ||
          got_log[0].last !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_first: got t0=%0d t4=%0d t8=%0d u%b l%b expected 0 5 10 u1 l0",
                 tap(got_log[0].data, 0), tap(got_log[0].data, 4), tap(got_log[0].data, 8),
                 got_log[0].user, got_log[0].last);
      end
      n_checks++;
      if (tap(got_log[1].data, 8) !== 8'd11 || got_log[1].last !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_second: got t8=%0d l%b expected 11 l1",
                 tap(got_log[1].data, 8), got_log[1].last);
      end
      n_checks++;
      if (tap(got_log[3].data, 0) !== 8'd5 || tap(got_log[3].data, 8) !== 8'd15 ||
          got_log[3].last !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_last: got t0=%0d t8=%0d l%b expected 5 15 l1",
                 tap(got_log[3].data, 0), tap(got_log[3].data, 8), got_log[3].last);
      end
    end
  endtask

  task automatic test_backpressure();
    start_scenario();
    axis.m_axis_tready = 1'b1;
    rdy_toggle = 1'b1;
    send_frame(0);
    drain();
    rdy_toggle = 1'b0;
    axis.m_axis_tready = 1'b1;
    n_checks++;
    if (n_win != 4) begin
      n_fail++;
      $display("FAIL bp_count: got %0d expected 4", n_win);
    end
    if (got_log.size() == 4) begin
      n_checks++;
      if (tap(got_log[0].data, 4) !== 8'd5 || tap(got_log[3].data, 8) !== 8'd15) begin
        n_fail++;
        $display("FAIL bp_taps: got %0d %0d expected 5 15",
                 tap(got_log[0].data, 4), tap(got_log[3].data, 8));
      end
    end
  endtask

  task automatic test_back_to_back();
    bit clean;
    start_scenario();
    send_frame(0);
    send_frame(16);
    drain();
    n_checks++;
    if (n_win != 8) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d expected 8", n_win);
    end
    if (got_log.size() == 8) begin
      n_checks++;
      if (tap(got_log[4].data, 0) !== 8'd16 || got_log[4].user !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_first: got t0=%0d u%b expected 16 u1",
                 tap(got_log[4].data, 0), got_log[4].user);
      end
      clean = 1'b1;
      for (int w = 4; w < 8; w++)
        for (int k = 0; k < 9; k++)
          if (tap(got_log[w].data, k) < 8'd16) clean = 1'b0;
      n_checks++;
      if (!clean) begin
        n_fail++;
        $display("FAIL b2b_stale: got first-frame tap expected none");
      end
    end
  endtask

  task automatic test_frame_start();
    start_scenario();
    for (int v = 0; v < 6; v++) send_pixel(v);
    frame_start = 1'b1;
    send_pixel(0);
    frame_start = 1'b0;
    for (int v = 1; v < 16; v++) send_pixel(v);
    drain();
    n_checks++;
    if (n_win != 4) begin
      n_fail++;
      $display("FAIL fs_count: got %0d expected 4", n_win);
    end
    if (got_log.size() == 4) begin
      n_checks++;
      if (tap(got_log[0].data, 0) !== 8'd0 || tap(got_log[0].data, 8) !== 8'd10 ||
          got_log[0].user !== 1'b1 || tap(got_log[3].data, 8) !== 8'd15) begin
        n_fail++;
        $display("FAIL fs_taps: got t0=%0d t8=%0d u%b last_t8=%0d expected 0 10 u1 15",
                 tap(got_log[0].data, 0), tap(got_log[0].data, 8), got_log[0].user,
                 tap(got_log[3].data, 8));
      end
    end
  endtask

  task automatic test_reset_midframe();
    bit acc;
    start_scenario();
    axis.m_axis_tready = 1'b0;
    for (int v = 0; v < 11; v++) send_pixel(v);
    axis.s_axis_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (axis.m_axis_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pending: got %b expected 1", axis.m_axis_tvalid);
    end
    cycle(acc);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({axis.m_axis_tvalid, axis.m_axis_tuser, axis.m_axis_tlast, frame_done} !== 4'b0 ||
        axis.m_axis_tdata !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got v%b d%h expected all zero",
               axis.m_axis_tvalid, axis.m_axis_tdata);
    end
    axis.m_axis_tready = 1'b1;
    start_scenario();
    send_frame(0);
    drain();
    n_checks++;
    if (n_win != 4) begin
      n_fail++;
      $display("FAIL rst_mid_count: got %0d expected 4", n_win);
    end
    if (got_log.size() == 4) begin
      n_checks++;
      if (tap(got_log[0].data, 4) !== 8'd5 || got_log[0].user !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_mid_first: got t4=%0d u%b expected 5 u1",
                 tap(got_log[0].data, 4), got_log[0].user);
      end
    end
  endtask

  task automatic test_enable();
    bit acc;
    start_scenario();
    for (int v = 0; v < 6; v++) send_pixel(v);
    axis.s_axis_tdata  = pix(6);
    axis.s_axis_tvalid = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(acc);
      n_checks++;
      if (acc !== 1'b0) begin
        n_fail++;
        $display("FAIL enable_hold: got accepted expected not-accepted");
      end
    end
    enable = 1'b1;
    for (int v = 6; v < 16; v++) send_pixel(v);
    drain();
    n_checks++;
    if (n_win != 4) begin
      n_fail++;
      $display("FAIL enable_count: got %0d expected 4", n_win);
    end
    if (got_log.size() == 4) begin
      n_checks++;
      if (tap(got_log[0].data, 8) !== 8'd10 || tap(got_log[3].data, 0) !== 8'd5) begin
        n_fail++;
        $display("FAIL enable_taps: got %0d %0d expected 10 5",
                 tap(got_log[0].data, 8), tap(got_log[3].data, 0));
      end
    end
  endtask

  initial begin
    axis.s_axis_tdata  = '0;
    axis.s_axis_tvalid = 1'b0;
    axis.m_axis_tready = 1'b1;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_frame_start();
    test_reset_midframe();
    test_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/line_window_3x3.md
Name: line_window_3x3

Overview:
- Downstream neighbour of the image preprocessing stage.
- Consumes the normalized {R,G,B} AXI-Stream pixel raster and produces a 3x3 sliding window of pixels per output beat, for the convolution front-end.
- Stores two full image lines on-chip and uses "valid" padding: no border windows are emitted.
- Tracks raster position and flags the first window of a frame and the last window of each row.

Parameters:
- WIDTH, 640, pixels per line (>=3)
- HEIGHT, 480, lines per frame (>=3)
- DATA_WIDTH, 8, bits per colour channel; pixel width PW = 3*DATA_WIDTH

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- enable  in  1  stage enable; gates s_axis_tready
- frame_start  in  1  one-cycle pulse; restarts raster position at pixel (0,0)
- s_axis_tdata  in  PW  input pixel {R,G,B}
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  9*PW  3x3 window; tap k=r*3+c at bits [(k+1)*PW-1 : k*PW]; r=0 top (oldest line), c=0 leftmost (oldest column)
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tuser  out  1  high on the first window of a frame
- m_axis_tlast  out  1  high on the last window of each row
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - col=0, row=0.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, frame_done=0.
  - Window registers cleared; line-buffer contents are don't-care.
  - A reset mid-frame discards any pending output beat.
- Handshakes:
  - s_axis_tready = enable && (!m_axis_tvalid || m_axis_tready).
  - in_fire = s_axis_tvalid && s_axis_tready.
  - out_fire = m_axis_tvalid && m_axis_tready.
  - tdata, tuser and tlast are held stable while tvalid=1 and tready=0.
- On in_fire at position (row, col):
  - Read lb0[col] (line row-1) and lb1[col] (line row-2).
  - Write lb1[col] <= lb0[col] and lb0[col] <= pixel.
  - Shift the window left one column; the new right column is {lb1[col], lb0[col], pixel} for r=0,1,2.
  - col increments. At WIDTH-1 it wraps to 0 and row increments. At row HEIGHT-1, col WIDTH-1, both wrap to 0 and frame_done pulses for one cycle.
- Output register:
  - Loaded on an in_fire where row>=2 && col>=2, with m_axis_tvalid set.
  - m_axis_tuser = (row==2 && col==2).
  - m_axis_tlast = (col==WIDTH-1).
  - Latency: window valid 1 cycle after the accepting edge.
  - On out_fire with no new qualifying in_fire, m_axis_tvalid clears.
  - Qualifying in_fire and out_fire in the same cycle: reload; tvalid stays 1 (full throughput, 1 window/cycle).
  - in_fire for a non-qualifying position: output unchanged, except tvalid clears if out_fire occurs.
- Window count: exactly (WIDTH-2)*(HEIGHT-2) windows per frame.
- frame_start:
  - Forces row=0, col=0.
  - If it coincides with in_fire, that pixel is taken as (0,0) and the next position is (0,1).
  - A pending output beat is not flushed.
  - Stale line-buffer data is never emitted, because row>=2 is required.
- enable=0: no input accepted; a pending output may still drain; counters hold.
- Widths: counters are $clog2(WIDTH) and $clog2(HEIGHT) bits. No arithmetic on pixel data; pixels pass through bit-exact.

Test Plan:
- WIDTH=4, HEIGHT=4, pixel p(row,col) = row*4+col replicated in R,G,B, streamed with m_axis_tready=1:
  - Exactly 4 windows.
  - First window (after 11th pixel) has tap0=0, tap4=5, tap8=10, tuser=1, tlast=0.
  - Second window has tap8=11, tlast=1.
  - Last window has tap0=5, tap8=15, tlast=1.
  - frame_done pulses on acceptance of pixel 15.
- Same stream with m_axis_tready toggling 1/0 every cycle: identical window sequence, no loss or duplication; tdata stable during stalls; s_axis_tready low whenever tvalid=1 and tready=0.
- Two back-to-back frames (second frame values +16): second frame yields 4 windows; first has tap0=16, tuser=1; no tap of any second-frame window contains first-frame data.
- frame_start pulsed after 6 pixels, then a full 16-pixel frame: exactly 4 windows, matching scenario 1 offsets; no window emitted from the aborted partial frame.
- rst_n=0 for one cycle mid-frame with m_axis_tvalid=1: next cycle m_axis_tvalid=0 and all outputs 0; a following full frame behaves as scenario 1.
- enable=0 for 5 cycles mid-row with s_axis_tvalid=1: s_axis_tready=0; counters hold; on re-enable the windows match the uninterrupted reference sequence.
